id_ex_register: RTL

ID/EX pipeline stage of the MIPS pipeline, directly downstream of the register file. It captures the two register-file read operands, the immediate and the decoded control of the instruction in ID, and presents them to EX one cycle later. It also detects load-use hazards against the instruction currently in EX, inserts a one-cycle bubble, and tells the upstream stages to stall. It supports flush (branch/jump redirect) and a downstream hold, and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_register.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_register #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [31:0]      id_read_data1,
  input  logic [31:0]      id_read_data2,
  input  logic [31:0]      id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic [1:0]       id_mem_to_reg,
  input  logic [1:0]       id_reg_dst,
  input  logic [3:0]       id_alu_op,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [31:0]      ex_read_data1,
  output logic [31:0]      ex_read_data2,
  output logic [31:0]      ex_imm,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic [1:0]       ex_mem_to_reg,
  output logic [3:0]       ex_alu_op,
  output logic [4:0]       ex_dst,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Everything EX needs from one instruction; an all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  mem_to_reg;
    logic [3:0]  alu_op;
    logic [4:0]  dst;
  } stage_t;

  stage_t           stage_q;
  stage_t           stage_d;
  stage_t           id_stage;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [4:0]       id_dst;
  logic             rs_match;
  logic             rt_match;
  logic             hazard;

  // Destination register resolution; the reserved encoding falls back to rt.
  always_comb begin
    id_dst = id_rt;
    case (id_reg_dst)
      2'd1:    id_dst = id_rd;
      2'd2:    id_dst = 5'd31;
      default: id_dst = id_rt;
    endcase
  end

  // Pack the ID-side fields into the stage payload.
  always_comb begin
    id_stage            = '0;
    id_stage.valid      = id_valid;
    id_stage.pc         = id_pc;
    id_stage.rs         = id_rs;
    id_stage.rt         = id_rt;
    id_stage.read_data1 = id_read_data1;
    id_stage.read_data2 = id_read_data2;
    id_stage.imm        = id_imm;
    id_stage.reg_write  = id_reg_write;
    id_stage.mem_read   = id_mem_read;
    id_stage.mem_write  = id_mem_write;
    id_stage.alu_src    = id_alu_src;
    id_stage.mem_to_reg = id_mem_to_reg;
    id_stage.alu_op     = id_alu_op;
    id_stage.dst        = id_dst;
  end

  // Load-use detection: a load in EX whose result the ID instruction reads; r0 is never a real dependency.
  always_comb begin
    rs_match = id_uses_rs & (id_rs == stage_q.dst);
    rt_match = id_uses_rt & (id_rt == stage_q.dst);
    hazard   = stage_q.valid & stage_q.mem_read & (stage_q.dst != 5'd0) &
               id_valid & (rs_match | rt_match);
  end

  // Upstream freeze; flush wins because the redirect replaces what ID holds anyway.
  always_comb begin
    stall = (hazard | ex_hold) & ~flush & reset;
  end

  // Next-state selection in priority order: flush, hold, load-use bubble, normal capture.
  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      stage_d = '0;
    end else if (ex_hold) begin
      stage_d = stage_q;
    end else if (hazard) begin
      stage_d = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
    end else begin
      stage_d = id_stage;
    end
  end

  // Stage and counter registers; reset clears immediately without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = stage_q.valid;
  assign ex_pc         = stage_q.pc;
  assign ex_rs         = stage_q.rs;
  assign ex_rt         = stage_q.rt;
  assign ex_read_data1 = stage_q.read_data1;
  assign ex_read_data2 = stage_q.read_data2;
  assign ex_imm        = stage_q.imm;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_alu_src    = stage_q.alu_src;
  assign ex_mem_to_reg = stage_q.mem_to_reg;
  assign ex_alu_op     = stage_q.alu_op;
  assign ex_dst        = stage_q.dst;
  assign bubble_count  = bubble_cnt_q;

endmodule
